// File: rtl/sbox_share_sched.sv
// Shares one byte S-box between a 128-bit state job and a 32-bit key-word job, one byte per cycle.
// A state job finishes 16 cycles after accept and a key job 4 cycles after accept; each raises a one-cycle done pulse. Both readies stay low while a job runs.
module sbox_share_sched #(
  parameter int KEY_PRIORITY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  input  logic         st_inv,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_in,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic [7:0]   sbox_in,
  output logic         sbox_inv,
  input  logic [7:0]   sbox_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
  } state_t;

  localparam logic KEY_WINS = (KEY_PRIORITY != 0);

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     cnt;
  logic [127:0]   sbuf;
  logic [31:0]    kbuf;
  logic           inv_q;
  logic           st_acc;
  logic           kw_acc;
  logic           st_last;
  logic           kw_last;

  assign st_acc  = st_valid && st_ready;
  assign kw_acc  = kw_valid && kw_ready;
  assign st_last = (state == ST_RUN) && (cnt == 4'd15);
  assign kw_last = (state == KW_RUN) && (cnt == 4'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (kw_acc) begin
          state_nxt = KW_RUN;
        end else if (st_acc) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == 4'd15) begin
          state_nxt = IDLE;
        end
      end
      KW_RUN: begin
        if (cnt == 4'd3) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readies only open in IDLE; the priority parameter decides who yields to a simultaneous request.
  always_comb begin
    st_ready = 1'b0;
    kw_ready = 1'b0;
    sbox_in  = 8'h00;
    sbox_inv = 1'b0;
    case (state)
      IDLE: begin
        kw_ready = !(!KEY_WINS && st_valid);
        st_ready = !(KEY_WINS && kw_valid);
      end
      ST_RUN: begin
        sbox_in  = sbuf[127:120];
        sbox_inv = inv_q;
      end
      KW_RUN: begin
        sbox_in  = kbuf[31:24];
        sbox_inv = 1'b0;
      end
      default: begin
        sbox_in  = 8'h00;
        sbox_inv = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 4'd0;
      sbuf  <= 128'd0;
      kbuf  <= 32'd0;
      inv_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (kw_acc) begin
            kbuf <= kw_in;
            cnt  <= 4'd0;
          end else if (st_acc) begin
            sbuf  <= st_in;
            inv_q <= st_inv;
            cnt   <= 4'd0;
          end
        end
        ST_RUN: begin
          // After 16 rotations the substituted bytes land back in their original positions.
          sbuf <= {sbuf[119:0], sbox_out};
          cnt  <= st_last ? 4'd0 : cnt + 4'd1;
        end
        KW_RUN: begin
          kbuf <= {kbuf[23:0], sbox_out};
          cnt  <= kw_last ? 4'd0 : cnt + 4'd1;
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_out  <= 128'd0;
      kw_out  <= 32'd0;
      st_done <= 1'b0;
      kw_done <= 1'b0;
    end else begin
      st_done <= st_last;
      kw_done <= kw_last;
      if (st_last) begin
        st_out <= {sbuf[119:0], sbox_out};
      end
      if (kw_last) begin
        kw_out <= {kbuf[23:0], sbox_out};
      end
    end
  end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed bench: DUT 0 has key priority, DUT 1 has state priority; the bench supplies the S-box tables.
module tb_sbox_share_sched;

  logic         clk;
  logic         rst;
  logic [127:0] st_in;
  logic         st_inv;
  logic [31:0]  kw_in;
  logic         st_valid [2];
  logic         kw_valid [2];
  logic         st_ready [2];
  logic         kw_ready [2];
  logic [127:0] st_out   [2];
  logic         st_done  [2];
  logic [31:0]  kw_out   [2];
  logic         kw_done  [2];
  logic [7:0]   sbox_in  [2];
  logic         sbox_inv [2];
  logic [7:0]   sbox_out [2];

  logic [7:0]    fwd_tab [256];
  logic [7:0]    inv_tab [256];
  logic [2047:0] fwd_bits;

  int n_checks;
  int n_fail;

  localparam logic [127:0] PT    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_S  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] PT2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2_S = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  KW    = 32'hcf4f3c09;
  localparam logic [31:0]  KW_S  = 32'h8a84eb01;

  sbox_share_sched #(.KEY_PRIORITY(1)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid[0]), .st_ready(st_ready[0]), .st_in(st_in), .st_inv(st_inv),
    .st_out(st_out[0]), .st_done(st_done[0]),
    .kw_valid(kw_valid[0]), .kw_ready(kw_ready[0]), .kw_in(kw_in),
    .kw_out(kw_out[0]), .kw_done(kw_done[0]),
    .sbox_in(sbox_in[0]), .sbox_inv(sbox_inv[0]), .sbox_out(sbox_out[0])
  );

  sbox_share_sched #(.KEY_PRIORITY(0)) dut_sp (
    .clk(clk), .rst(rst),
    .st_valid(st_valid[1]), .st_ready(st_ready[1]), .st_in(st_in), .st_inv(st_inv),
    .st_out(st_out[1]), .st_done(st_done[1]),
    .kw_valid(kw_valid[1]), .kw_ready(kw_ready[1]), .kw_in(kw_in),
    .kw_out(kw_out[1]), .kw_done(kw_done[1]),
    .sbox_in(sbox_in[1]), .sbox_inv(sbox_inv[1]), .sbox_out(sbox_out[1])
  );

  assign sbox_out[0] = sbox_inv[0] ? inv_tab[sbox_in[0]] : fwd_tab[sbox_in[0]];
  assign sbox_out[1] = sbox_inv[1] ? inv_tab[sbox_in[1]] : fwd_tab[sbox_in[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One state job on DUT d; done expected in the 17th cycle after the accept cycle.
  task automatic run_state(input int d, input logic [127:0] data, input logic inv,
                           input logic [127:0] exp);
    int bad_ready = 0;
    int bad_inv = 0;
    int early = 0;
    @(negedge clk);
    st_in = data;
    st_inv = inv;
    st_valid[d] = 1'b1;
    #1;
    chk("st_ready_idle", 128'(st_ready[d]), 128'd1);
    @(negedge clk);
    st_valid[d] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (st_ready[d] !== 1'b0) bad_ready++;
      if (sbox_inv[d] !== inv) bad_inv++;
      if (st_done[d] !== 1'b0) early++;
      @(negedge clk);
    end
    #1;
    chk("st_done_pulse", 128'(st_done[d]), 128'd1);
    chk("st_out", st_out[d], exp);
    chk("st_ready_run", 128'(bad_ready), 128'd0);
    chk("sbox_inv_run", 128'(bad_inv), 128'd0);
    chk("st_done_early", 128'(early), 128'd0);
    @(negedge clk);
    #1;
    chk("st_done_width", 128'(st_done[d]), 128'd0);
    chk("st_out_hold", st_out[d], exp);
  endtask

  task automatic run_key(input int d, input logic [31:0] data, input logic [31:0] exp);
    int bad_inv = 0;
    int early = 0;
    logic [127:0] st_before;
    @(negedge clk);
    st_before = st_out[d];
    kw_in = data;
    kw_valid[d] = 1'b1;
    #1;
    chk("kw_ready_idle", 128'(kw_ready[d]), 128'd1);
    @(negedge clk);
    kw_valid[d] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (sbox_inv[d] !== 1'b0) bad_inv++;
      if (kw_done[d] !== 1'b0) early++;
      @(negedge clk);
    end
    #1;
    chk("kw_done_pulse", 128'(kw_done[d]), 128'd1);
    chk("kw_out", 128'(kw_out[d]), 128'(exp));
    chk("kw_sbox_inv", 128'(bad_inv), 128'd0);
    chk("kw_done_early", 128'(early), 128'd0);
    chk("st_out_untouched", st_out[d], st_before);
    @(negedge clk);
    #1;
    chk("kw_done_width", 128'(kw_done[d]), 128'd0);
  endtask

  // Both requests raised together; accept/done cycle numbers are relative to the first request cycle.
  task automatic run_contention(input int d, input bit key_first);
    int st_acc = -1, kw_acc = -1, st_dc = -1, kw_dc = -1, st_dn = 0, kw_dn = 0;
    logic [127:0] st_res = '0;
    logic [31:0]  kw_res = '0;
    @(negedge clk);
    st_in = PT;
    st_inv = 1'b0;
    kw_in = KW;
    st_valid[d] = 1'b1;
    kw_valid[d] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (st_done[d]) begin st_dn++; st_dc = c; st_res = st_out[d]; end
      if (kw_done[d]) begin kw_dn++; kw_dc = c; kw_res = kw_out[d]; end
      if (st_valid[d] && st_ready[d]) st_acc = c;
      if (kw_valid[d] && kw_ready[d]) kw_acc = c;
      @(negedge clk);
      if (st_acc >= 0) st_valid[d] = 1'b0;
      if (kw_acc >= 0) kw_valid[d] = 1'b0;
    end
    chk("ct_kw_accept", 128'(kw_acc), key_first ? 128'd0 : 128'd17);
    chk("ct_st_accept", 128'(st_acc), key_first ? 128'd5 : 128'd0);
    chk("ct_kw_done_cyc", 128'(kw_dc), key_first ? 128'd5 : 128'd22);
    chk("ct_st_done_cyc", 128'(st_dc), key_first ? 128'd22 : 128'd17);
    chk("ct_kw_done_cnt", 128'(kw_dn), 128'd1);
    chk("ct_st_done_cnt", 128'(st_dn), 128'd1);
    chk("ct_kw_out", 128'(kw_res), 128'(KW_S));
    chk("ct_st_out", st_res, PT_S);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    fwd_bits = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) fwd_tab[i] = fwd_bits[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    rst = 1'b1;
    st_in = '0;
    st_inv = 1'b0;
    kw_in = '0;
    for (int d = 0; d < 2; d++) begin
      st_valid[d] = 1'b0;
      kw_valid[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_st_out", st_out[0], 128'd0);
    chk("rst_kw_out", 128'(kw_out[0]), 128'd0);
    chk("rst_st_done", 128'(st_done[0]), 128'd0);
    chk("rst_kw_done", 128'(kw_done[0]), 128'd0);
    chk("rst_sbox_in", 128'(sbox_in[0]), 128'd0);
    chk("rst_sbox_inv", 128'(sbox_inv[0]), 128'd0);
    chk("rst_st_ready", 128'(st_ready[0]), 128'd1);
    chk("rst_kw_ready", 128'(kw_ready[0]), 128'd1);
    @(negedge clk);
    rst = 1'b0;

    run_state(0, PT, 1'b0, PT_S);
    run_state(0, PT_S, 1'b1, PT);
    run_key(0, KW, KW_S);
    run_state(0, PT2, 1'b0, PT2_S);

    run_contention(0, 1'b1);
    run_contention(1, 1'b0);

    // Reset while the state job is at byte 7.
    @(negedge clk);
    st_in = PT2;
    st_inv = 1'b0;
    st_valid[0] = 1'b1;
    @(negedge clk);
    st_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_st_out", st_out[0], 128'd0);
    chk("mid_rst_kw_out", 128'(kw_out[0]), 128'd0);
    chk("mid_rst_st_done", 128'(st_done[0]), 128'd0);
    chk("mid_rst_sbox_in", 128'(sbox_in[0]), 128'd0);
    chk("mid_rst_st_ready", 128'(st_ready[0]), 128'd1);
    rst = 1'b0;
    begin
      int stray = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        #1;
        if (st_done[0] !== 1'b0) stray++;
      end
      chk("mid_rst_no_done", 128'(stray), 128'd0);
    end
    run_state(0, PT2, 1'b0, PT2_S);

    // Back-to-back state jobs with st_valid held high.
    begin
      int acc_n = 0, done_n = 0;
      int acc_c [2];
      int done_c [2];
      logic [127:0] done_v [2];
      acc_c = '{-1, -1};
      done_c = '{-1, -1};
      done_v = '{128'd0, 128'd0};
      @(negedge clk);
      st_in = PT;
      st_inv = 1'b0;
      st_valid[0] = 1'b1;
      for (int c = 0; c < 45; c++) begin
        #1;
        if (st_done[0]) begin
          if (done_n < 2) begin done_c[done_n] = c; done_v[done_n] = st_out[0]; end
          done_n++;
        end
        if (st_valid[0] && st_ready[0]) begin
          if (acc_n < 2) acc_c[acc_n] = c;
          acc_n++;
        end
        @(negedge clk);
        if (acc_n == 1) st_in = PT2;
        if (acc_n >= 2) st_valid[0] = 1'b0;
      end
      chk("b2b_accepts", 128'(acc_n), 128'd2);
      chk("b2b_acc2_cyc", 128'(acc_c[1]), 128'd17);
      chk("b2b_done1_cyc", 128'(done_c[0]), 128'd17);
      chk("b2b_done2_cyc", 128'(done_c[1]), 128'd34);
      chk("b2b_done_cnt", 128'(done_n), 128'd2);
      chk("b2b_out1", done_v[0], PT_S);
      chk("b2b_out2", done_v[1], PT2_S);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_share_sched.md
# sbox_share_sched

Time-multiplexes one combinational byte S-box between the two AES consumers of SubBytes: the round datapath (128-bit state) and the key expansion (32-bit SubWord). It accepts one job at a time through valid/ready handshakes and streams the job's bytes through the shared S-box, one per cycle. It reassembles the results and returns them with a one-cycle done pulse. It sits between the round controller, the key scheduler and the single shared S-box instance.

## Interface
- `KEY_PRIORITY`, default 1: 1 = key request wins a simultaneous request at IDLE; 0 = state request wins.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `st_valid` in 1: state job request.
- `st_ready` out 1: state job accepted when `st_valid && st_ready` at an edge.
- `st_in` in 128: state, byte 0 = bits 127:120.
- `st_inv` in 1: 1 = inverse S-box for this job; captured at accept.
- `st_out` out 128: substituted state, same byte order.
- `st_done` out 1: one-cycle pulse, `st_out` valid.
- `kw_valid` in 1: key word job request.
- `kw_ready` out 1: key job handshake.
- `kw_in` in 32: word, byte 0 = bits 31:24.
- `kw_out` out 32: SubWord result.
- `kw_done` out 1: one-cycle pulse, `kw_out` valid.
- `sbox_in` out 8: byte to shared S-box.
- `sbox_inv` out 1: S-box direction select.
- `sbox_out` in 8: combinational S-box result of `sbox_in`.

## Operation
- FSM states: IDLE, ST_RUN, KW_RUN.
- IDLE:
  - `kw_ready` = 1 unless (`KEY_PRIORITY`=0 and `st_valid`=1).
  - `st_ready` = 1 unless (`KEY_PRIORITY`=1 and `kw_valid`=1).
  - Both readies are 0 in RUN states. Jobs are non-preemptive.
- State accept:
  - Load `st_in` into 128-bit working register `sbuf`, latch `st_inv`, clear byte counter `cnt`, go ST_RUN.
- ST_RUN:
  - `sbox_in` = `sbuf[127:120]`, `sbox_inv` = latched inv.
  - Each edge: `sbuf` <= {`sbuf[119:0]`, `sbox_out`}, `cnt`++.
  - At the edge where `cnt`=15: `st_out` <= final rotated value, `st_done` <= 1, go IDLE.
  - After 16 rotations the bytes are back in their original order.
- Key accept:
  - Load `kw_in` into `kbuf`, clear `cnt`, go KW_RUN.
- KW_RUN:
  - `sbox_in` = `kbuf[31:24]`, `sbox_inv` = 0 always (key expansion uses the forward S-box only).
  - Same rotate/insert per edge.
  - At `cnt`=3: `kw_out` <= result, `kw_done` <= 1, go IDLE.
- In IDLE, `sbox_in` = 0 and `sbox_inv` = 0.
- `cnt` is 4 bits and compares exactly: no wrap beyond 15, and KW_RUN ends at 3.
- `st_out`/`kw_out` hold their last result until overwritten by the next completion of the same job type.
- Done pulses are exactly one cycle.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0.
  - `st_out` = 0, `kw_out` = 0, `st_done` = 0, `kw_done` = 0.
  - `sbox_in` = 0, `sbox_inv` = 0, `sbuf`/`kbuf` = 0.
- Ready: `st_ready` and `kw_ready` are combinational from FSM state and valids. After reset they take their IDLE values.
- Latency: with accept at edge E, `st_done` is high in the cycle following edge E+16. `kw_done` follows edge E+4.
- The cycle in which a done pulse is high is also IDLE, so a new job may be accepted at the edge ending that cycle.
  - Throughput: 17 cycles per state job, 5 per key job.
- Simultaneous valids at IDLE: the winner is accepted per `KEY_PRIORITY`. The loser remains pending and is accepted at the first IDLE edge after the winner's job completes (it is not dropped).
- Reset mid-job:
  - The job is aborted and no done pulse is issued.
  - Outputs return to their reset values.
  - A requester must re-present its job after reset.
- The S-box path is combinational: `sbox_in` → `sbox_out` must settle within one cycle; `sbox_out` is sampled at every RUN edge.

## Test plan
- State forward: `st_in` = 000102030405060708090a0b0c0d0e0f, `st_inv` = 0 → after 16 RUN edges `st_out` = 637c777bf26b6fc53001672bfed7ab76, `st_done` high exactly 1 cycle, `st_ready` low for those 16 cycles.
- State inverse: `st_in` = 637c777bf26b6fc53001672bfed7ab76, `st_inv` = 1 → `st_out` = 000102030405060708090a0b0c0d0e0f; `sbox_inv` = 1 throughout the RUN.
- Key word: `kw_in` = cf4f3c09 → `kw_out` = 8a84eb01, `kw_done` after edge E+4, `sbox_inv` = 0 throughout; `st_out` unchanged.
- Contention: `st_valid` and `kw_valid` both asserted at IDLE with `KEY_PRIORITY` = 1 → key job runs first; state job is accepted in the `kw_done` cycle's edge; both results are correct. Repeat with `KEY_PRIORITY` = 0 → state job runs first.
- Reset mid-job: assert `rst` at `cnt` = 7 of a state job → next cycle FSM = IDLE, all outputs 0, no `st_done`; re-submitted job completes correctly.
- Back-to-back: two state jobs with continuous `st_valid` → second accept at the edge ending the first `st_done` cycle; done pulses 17 cycles apart.
